// File: rtl/matrix_frame_scheduler_if.sv
// Requester/display bundle for matrix_frame_scheduler: two back-buffer writers
// (A = game engine, B = scroller) plus the LED matrix drive and status pulses.
interface matrix_frame_scheduler_if;
  logic       a_req;
  logic       a_we;
  logic [2:0] a_row;
  logic [7:0] a_r;
  logic [7:0] a_g;
  logic       a_swap;
  logic       b_req;
  logic       b_we;
  logic [2:0] b_row;
  logic [7:0] b_r;
  logic [7:0] b_g;
  logic       b_swap;
  logic       a_gnt;
  logic       b_gnt;
  logic       swap_done;
  logic       frame_start;
  logic [7:0] matrix_scanout;
  logic [7:0] matrix_segout_r;
  logic [7:0] matrix_segout_g;

  modport master (
    output a_req, a_we, a_row, a_r, a_g, a_swap,
    output b_req, b_we, b_row, b_r, b_g, b_swap,
    input  a_gnt, b_gnt, swap_done, frame_start,
    input  matrix_scanout, matrix_segout_r, matrix_segout_g
  );

  modport slave (
    input  a_req, a_we, a_row, a_r, a_g, a_swap,
    input  b_req, b_we, b_row, b_r, b_g, b_swap,
    output a_gnt, b_gnt, swap_done, frame_start,
    output matrix_scanout, matrix_segout_r, matrix_segout_g
  );
endinterface

// File: rtl/matrix_frame_scheduler.sv
// Double-buffered 8x8 bicolor LED frame store with row scanning, A/B write arbitration
// and tear-free swaps on frame boundaries. Define MATRIX_BLANK_EN for per-row blanking.
module matrix_frame_scheduler #(
  parameter int unsigned SCAN_DIV     = 8192,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input logic                      clk,
  input logic                      reset,
  matrix_frame_scheduler_if.slave  bus
);

  localparam int unsigned      DW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0]    DIV_LAST  = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0]    BLANK_LEN = DW'(BLANK_CYCLES);
`ifdef MATRIX_BLANK_EN
  localparam bit               BLANK_ON  = 1'b1;
`else
  localparam bit               BLANK_ON  = 1'b0;
`endif

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OWN_A = 2'd1;
  localparam logic [1:0] ST_OWN_B = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          last_b_q, last_b_d;   // 1 = B was served last
  logic [DW-1:0] div_q, div_d;
  logic [2:0]    row_q, row_d;
  logic          front_q, front_d;
  logic          pending_q, pending_d;
  logic          swap_done_q, frame_start_q;
  logic [7:0]    scan_q, seg_r_q, seg_g_q;
  logic [7:0]    scan_d, seg_r_d, seg_g_d;
  logic [7:0]    buf_r_q [2][8];
  logic [7:0]    buf_g_q [2][8];

  logic       a_gnt, b_gnt, wr_en, swap_req, wrap, boundary, apply, blank;
  logic [2:0] wr_row;
  logic [7:0] wr_r, wr_g;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    last_b_d = last_b_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.a_req && (!bus.b_req || last_b_q)) state_d = ST_OWN_A;
        else if (bus.b_req)                        state_d = ST_OWN_B;
      end
      ST_OWN_A: if (!bus.a_req) begin
        state_d  = ST_IDLE;
        last_b_d = 1'b0;
      end
      ST_OWN_B: if (!bus.b_req) begin
        state_d  = ST_IDLE;
        last_b_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Grants decode straight from state so an async reset drops them at once.
  assign a_gnt    = (state_q == ST_OWN_A);
  assign b_gnt    = (state_q == ST_OWN_B);
  assign wr_en    = (bus.a_we && a_gnt) || (bus.b_we && b_gnt);
  assign wr_row   = a_gnt ? bus.a_row : bus.b_row;
  assign wr_r     = a_gnt ? bus.a_r   : bus.b_r;
  assign wr_g     = a_gnt ? bus.a_g   : bus.b_g;
  assign swap_req = (bus.a_swap && a_gnt) || (bus.b_swap && b_gnt);

  assign wrap      = (div_q == DIV_LAST);
  assign boundary  = wrap && (row_q == 3'd7);
  assign apply     = boundary && pending_q;
  assign div_d     = wrap ? '0 : div_q + 1'b1;
  assign row_d     = wrap ? row_q + 3'd1 : row_q;
  assign front_d   = front_q ^ apply;
  // A request landing on the boundary edge survives the clear and waits one frame.
  assign pending_d = (pending_q && !apply) || swap_req;

  // Outputs are built from next-cycle row/front so a new frame appears with frame_start.
  assign blank   = BLANK_ON && (div_d < BLANK_LEN);
  assign scan_d  = 8'd1 << row_d;
  assign seg_r_d = blank ? 8'd0 : buf_r_q[front_d][row_d];
  assign seg_g_d = blank ? 8'd0 : buf_g_q[front_d][row_d];

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      last_b_q      <= 1'b1;
      div_q         <= '0;
      row_q         <= 3'd0;
      front_q       <= 1'b0;
      pending_q     <= 1'b0;
      swap_done_q   <= 1'b0;
      frame_start_q <= 1'b0;
      scan_q        <= 8'b0000_0001;
      seg_r_q       <= 8'd0;
      seg_g_q       <= 8'd0;
    end else begin
      state_q       <= state_d;
      last_b_q      <= last_b_d;
      div_q         <= div_d;
      row_q         <= row_d;
      front_q       <= front_d;
      pending_q     <= pending_d;
      swap_done_q   <= apply;
      frame_start_q <= boundary;
      scan_q        <= scan_d;
      seg_r_q       <= seg_r_d;
      seg_g_q       <= seg_g_d;
    end
  end

  // NOTE: the frame store is cleared by reset so the display is blank afterwards;
  // this forces it into flops rather than a RAM macro, which is fine at 256 bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < 8; r++) begin
          buf_r_q[b][r] <= 8'd0;
          buf_g_q[b][r] <= 8'd0;
        end
      end
    end else if (wr_en) begin
      buf_r_q[~front_q][wr_row] <= wr_r;
      buf_g_q[~front_q][wr_row] <= wr_g;
    end
  end

  assign bus.a_gnt           = a_gnt;
  assign bus.b_gnt           = b_gnt;
  assign bus.swap_done       = swap_done_q;
  assign bus.frame_start     = frame_start_q;
  assign bus.matrix_scanout  = scan_q;
  assign bus.matrix_segout_r = seg_r_q;
  assign bus.matrix_segout_g = seg_g_q;

endmodule

// File: tb/tb_matrix_frame_scheduler.sv
// Scoreboard bench for matrix_frame_scheduler with SCAN_DIV=4 (32-cycle frames):
// stimulus queues hand-computed expectations, a negedge monitor pops and compares.
module tb_matrix_frame_scheduler;
  localparam int SD = 4;
  localparam int BC = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  matrix_frame_scheduler_if bus ();

  matrix_frame_scheduler #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Cycle k = number of rising edges since reset release; sampled at negedge k.
  int cyc;
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct {
    int         cyc;
    logic [7:0] scan;
    logic [7:0] r;
    logic [7:0] g;
  } disp_t;

  typedef struct {
    int   cyc;
    logic a;
    logic b;
  } gnt_t;

  disp_t disp_q[$];
  gnt_t  gnt_q[$];
  int    swap_q[$];
  int    fs_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  disp_t mon_d;
  gnt_t  mon_g;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_disp(input int c, input int row, input logic [7:0] r, input logic [7:0] g);
    disp_t e;
    e.cyc  = c;
    e.scan = 8'd1 << row;
    e.r    = r;
    e.g    = g;
    disp_q.push_back(e);
  endtask

  task automatic exp_gnt(input int c, input logic a, input logic b);
    gnt_t e;
    e.cyc = c;
    e.a   = a;
    e.b   = b;
    gnt_q.push_back(e);
  endtask

  task automatic idle_inputs();
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_row = 3'd0; bus.a_r = 8'd0; bus.a_g = 8'd0; bus.a_swap = 1'b0;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_row = 3'd0; bus.b_r = 8'd0; bus.b_g = 8'd0; bus.b_swap = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Monitor: compares whatever the DUT presents against the head of each queue.
  always @(negedge clk) begin
    if (bus.swap_done) begin
      if (swap_q.size() == 0) check("swap_done_unexpected", bus.swap_done, 0);
      else                    check("swap_done_cycle", cyc, swap_q.pop_front());
    end
    if (bus.frame_start) begin
      if (fs_q.size() == 0) check("frame_start_unexpected", bus.frame_start, 0);
      else                  check("frame_start_cycle", cyc, fs_q.pop_front());
    end
    while (disp_q.size() > 0 && disp_q[0].cyc == cyc) begin
      mon_d = disp_q.pop_front();
      check("scanout", bus.matrix_scanout, mon_d.scan);
      check("segout_r", bus.matrix_segout_r, mon_d.r);
      check("segout_g", bus.matrix_segout_g, mon_d.g);
    end
    while (gnt_q.size() > 0 && gnt_q[0].cyc == cyc) begin
      mon_g = gnt_q.pop_front();
      check("a_gnt", bus.a_gnt, mon_g.a);
      check("b_gnt", bus.b_gnt, mon_g.b);
    end
`ifdef MATRIX_BLANK_EN
    if (reset && cyc > 0 && (cyc % SD) < BC) begin
      check("blank_r", bus.matrix_segout_r, 0);
      check("blank_g", bus.matrix_segout_g, 0);
    end
`endif
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();

    // Reset values, then a plain scan of an all-zero frame.
    exp_disp(0, 0, 8'h00, 8'h00);
    exp_gnt(0, 1'b0, 1'b0);
    for (int r = 0; r < 8; r++) exp_disp(3 + 4 * r, r, 8'h00, 8'h00);
    exp_disp(35, 0, 8'h00, 8'h00);
    for (int f = 1; f <= 6; f++) fs_q.push_back(32 * f);

    // Simultaneous requests: A first, one idle cycle, then B.
    exp_gnt(37, 1'b1, 1'b0);
    exp_gnt(39, 1'b0, 1'b0);
    exp_gnt(40, 1'b0, 1'b1);
    exp_gnt(43, 1'b0, 1'b0);
    exp_disp(47, 3, 8'h00, 8'h00);
    swap_q.push_back(64);
    exp_disp(67, 0, 8'h81, 8'h18);
    exp_disp(79, 3, 8'hAA, 8'h55);
    exp_disp(87, 5, 8'h00, 8'h00);

    // Ungranted B swap: row 6 data stays hidden for two frames.
    exp_gnt(89, 1'b1, 1'b0);
    exp_disp(123, 6, 8'h00, 8'h00);
    exp_disp(131, 0, 8'h81, 8'h18);
    exp_disp(155, 6, 8'h00, 8'h00);

    // Swap on the boundary edge is deferred a frame; write on the swap edge shows up.
    exp_gnt(157, 1'b1, 1'b0);
    exp_disp(187, 6, 8'h00, 8'h00);
    exp_gnt(190, 1'b1, 1'b0);
    swap_q.push_back(192);
    exp_gnt(193, 1'b0, 1'b0);
    exp_disp(195, 0, 8'h00, 8'h00);
    exp_disp(203, 2, 8'h99, 8'h66);
    exp_disp(219, 6, 8'h3C, 8'hC3);
    exp_gnt(221, 1'b1, 1'b0);

    repeat (2) @(negedge clk);
    #2 reset = 1'b1;

    wait_cyc(36);  bus.a_req = 1'b1; bus.b_req = 1'b1;
    wait_cyc(37);  bus.a_we = 1'b1; bus.a_row = 3'd3; bus.a_r = 8'hAA; bus.a_g = 8'h55;
    wait_cyc(38);  bus.a_we = 1'b0; bus.a_req = 1'b0;
    wait_cyc(40);  bus.b_we = 1'b1; bus.b_row = 3'd0; bus.b_r = 8'h81; bus.b_g = 8'h18;
                   bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_row = 3'd5; bus.a_r = 8'hFF; bus.a_g = 8'hFF;
    wait_cyc(41);  bus.b_we = 1'b0; bus.a_we = 1'b0; bus.b_swap = 1'b1;
    wait_cyc(42);  bus.b_req = 1'b0; bus.a_req = 1'b0;
    wait_cyc(43);  bus.b_swap = 1'b0;

    wait_cyc(88);  bus.a_req = 1'b1;
    wait_cyc(89);  bus.a_we = 1'b1; bus.a_row = 3'd6; bus.a_r = 8'h3C; bus.a_g = 8'hC3;
    wait_cyc(90);  bus.a_we = 1'b0; bus.b_swap = 1'b1;
    wait_cyc(91);  bus.b_swap = 1'b0; bus.a_req = 1'b0;

    wait_cyc(156); bus.a_req = 1'b1;
    wait_cyc(159); bus.a_swap = 1'b1;
    wait_cyc(160); bus.a_swap = 1'b0; bus.a_req = 1'b0;
    wait_cyc(189); bus.a_req = 1'b1;
    wait_cyc(191); bus.a_we = 1'b1; bus.a_row = 3'd2; bus.a_r = 8'h99; bus.a_g = 8'h66;
    wait_cyc(192); bus.a_we = 1'b0; bus.a_req = 1'b0;

    // Reset mid-burst with a swap pending.
    wait_cyc(220); bus.a_req = 1'b1;
    wait_cyc(221); bus.a_swap = 1'b1;
    wait_cyc(222); bus.a_swap = 1'b0; bus.a_we = 1'b1; bus.a_row = 3'd1; bus.a_r = 8'h77; bus.a_g = 8'h77;
    #2 reset = 1'b0;
    #1;
    check("async_a_gnt", bus.a_gnt, 0);
    check("async_b_gnt", bus.b_gnt, 0);
    check("async_scanout", bus.matrix_scanout, 8'h01);
    idle_inputs();
    exp_disp(0, 0, 8'h00, 8'h00);
    exp_gnt(0, 1'b0, 1'b0);
    for (int r = 0; r < 8; r++) exp_disp(35 + 4 * r, r, 8'h00, 8'h00);
    fs_q.push_back(32);
    fs_q.push_back(64);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;

    wait_cyc(70);
    check("disp_q_drained", disp_q.size(), 0);
    check("gnt_q_drained", gnt_q.size(), 0);
    check("swap_q_drained", swap_q.size(), 0);
    check("fs_q_drained", fs_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_frame_scheduler.md
# matrix_frame_scheduler

- Owns the 8x8 bicolor LED matrix.
- Holds a double-buffered frame store (front buffer displayed, back buffer written).
- Scans the front buffer row by row.
- Arbitrates back-buffer write access between two requesters: A = game engine, B = banner/score scroller.
- Commits a back-to-front swap only on a frame boundary, so scan output never tears.

## Interface
Parameters:
- SCAN_DIV, 8192: clk cycles per displayed row; legal range ≥ 4.
- BLANK_CYCLES, 16: row blanking length when BLANK_EN is defined; must be < SCAN_DIV.

Ports. Reset: `reset`, asynchronous, active-low. Clock: `clk`.
- clk  in  1  system clock
- reset  in  1  async active-low reset
- a_req  in  1  requester A wants buffer ownership; hold high for the whole burst
- a_we  in  1  A row write strobe
- a_row  in  3  A target row
- a_r, a_g  in  8 each  A row data, red/green, bit 7 = column 0
- a_swap  in  1  A commit request, 1-cycle pulse
- b_req, b_we, b_row, b_r, b_g, b_swap  in  as for A  requester B
- a_gnt, b_gnt  out  1 each  ownership grants
- swap_done  out  1  1-cycle pulse when a swap is applied
- frame_start  out  1  1-cycle pulse when row 0 begins
- matrix_scanout  out  8  one-hot row select
- matrix_segout_r, matrix_segout_g  out  8 each  column data for current row

## Operation
Reset values:
- a_gnt = b_gnt = 0, swap_done = 0, frame_start = 0.
- matrix_scanout = 8'b00000001; segout_r/g = 0.
- Row counter = 0, divider = 0.
- Both buffers all zero; front select = buffer 0; swap_pending = 0; last_served = B.

Arbiter FSM (IDLE, OWN_A, OWN_B):
- IDLE, exactly one req high → go to that requester's state.
- IDLE, both high → grant the requester ≠ last_served (A wins first after reset).
- OWN_x → IDLE when x_req is low; last_served = x.
- No direct OWN_A↔OWN_B transition: at least 1 IDLE cycle between owners.
- a_gnt = (state == OWN_A); b_gnt = (state == OWN_B).

Writes:
- Write only when x_we && x_gnt at the clock edge.
- Writes x_r/x_g into back[x_row]; last write to a row wins.
- we from a non-granted requester is ignored.

Swap:
- x_swap && x_gnt sets swap_pending. An ungranted swap is ignored.
- At a frame boundary (divider == SCAN_DIV-1 && row == 7) with swap_pending set: toggle front select, clear swap_pending, pulse swap_done next cycle.
- No copy on swap: the new back buffer holds the previous frame.

Scan:
- Divider counts 0..SCAN_DIV-1 and wraps; the row increments on wrap (7 → 0).
- Outputs are registered: scanout = 1<<row, segout = front[row].
- frame_start pulses in the cycle the row becomes 0.

Boundary conditions:
- Swap request on the boundary cycle itself: latched, applied at the next boundary.
- Write on the swap edge: lands in the pre-swap back buffer, i.e. becomes visible in the new frame.
- Multiple swaps before a boundary: one swap only.
- Requester drops req with a swap pending: the swap is still applied.
- Reset mid-frame or mid-burst: immediate return to reset values, grants drop asynchronously, buffer contents cleared.

## Timing
- Grant latency: 1 cycle (req high at edge n → gnt high after edge n).
- Release latency: 1 cycle.
- Write: visible in back buffer 1 cycle after the accepting edge.
- Frame period: 8·SCAN_DIV cycles.
- Row output update: 1 cycle after divider wrap.
- Swap-to-display: new front row 0 appears on the same edge that pulses frame_start; swap_done pulses coincident with that frame_start.

## Configuration
BLANK_EN (macro name MATRIX_BLANK_EN):
- Defined: for the first BLANK_CYCLES cycles of each row, segout_r/g are forced to 0 while scanout already selects the new row (anti-ghosting); front data is driven from cycle BLANK_CYCLES on. frame_start and swap timing are unchanged.
- Undefined: segout shows row data for the whole row period; parameter BLANK_CYCLES is unused.

## Test plan
- Reset, SCAN_DIV=4: scanout cycles 01,02,04..80 every 4 cycles; segout = 0; frame_start every 32 cycles.
- A req, write row3 r=8'hAA g=8'h55, swap → swap_done at next boundary; row 3 shows AA/55; other rows 0.
- A and B req simultaneously after reset → a_gnt first; A releases → 1 IDLE cycle → b_gnt; B write to row 0 accepted; A write during B ownership ignored.
- Ungranted b_swap while A owns → no swap_done; back data stays hidden for ≥ 2 frames.
- a_swap on the boundary cycle → swap deferred one frame (swap_done 32 cycles later, SCAN_DIV=4).
- Assert reset mid-burst with swap pending → gnt drops immediately, no swap_done after release, display all zero; with MATRIX_BLANK_EN, BLANK_CYCLES=2: segout = 0 for the first 2 cycles of each row.
